// File: rtl/walk_service_controller.sv
// Pedestrian walk service: request a slot, time WALK then flashing DON'T-WALK, release the slot.
// Latency: walk_req 1 cycle after a pending walk is seen with no grant; all outputs registered.
// Backpressure: waits in REQ for walk_ack; ticks are ignored until the grant arrives.
//
// Ports:
//   clk, sys_reset (async, active-low)  - clock and reset
//   tick                                - one-cycle timebase enable
//   walkRegister_status                 - pending-walk flag from the walk register
//   walk_ack                            - grant from the main sequencer (all vehicle heads red)
//   walk_req / walk_done                - slot request / one-cycle release pulse
//   walkRegister_reset                  - one-cycle clear pulse on the first WALK cycle
//   walk_light / dont_walk_light        - pedestrian lamps
//   walk_busy                           - high whenever not idle
module walk_service_controller #(
  parameter int WALK_TIME  = 8,
  parameter int FLASH_TIME = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic tick,
  input  logic walkRegister_status,
  input  logic walk_ack,
  output logic walk_req,
  output logic walk_done,
  output logic walkRegister_reset,
  output logic walk_light,
  output logic dont_walk_light,
  output logic walk_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WALK,
    S_FLASH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               walk_req_q, walk_req_d;
  logic               walk_done_q, walk_done_d;
  logic               wr_reset_q, wr_reset_d;
  logic               walk_light_q, walk_light_d;
  logic               dont_walk_q, dont_walk_d;
  logic               walk_busy_q, walk_busy_d;

  // Next state and counter. The counter holds "ticks remaining minus one",
  // so the tick that finds it at zero is the last one of the interval.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // A grant still held from the previous slot blocks a new request.
        if (walkRegister_status && !walk_ack) state_d = S_REQ;
      end
      S_REQ: begin
        if (walk_ack) begin
          state_d = S_WALK;
          cnt_d   = CNT_W'(WALK_TIME - 1);
        end
      end
      S_WALK: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = S_FLASH;
            cnt_d   = CNT_W'(FLASH_TIME - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_FLASH: begin
        if (tick) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    walk_req_d   = (state_d == S_REQ) || (state_d == S_WALK) || (state_d == S_FLASH);
    walk_done_d  = (state_d == S_DONE);
    wr_reset_d   = (state_d == S_WALK) && (state_q == S_REQ);
    walk_light_d = (state_d == S_WALK);
    walk_busy_d  = (state_d != S_IDLE);
    if (state_d == S_FLASH) begin
      // FLASH starts solid, then toggles on every tick that stays in FLASH.
      if (state_q != S_FLASH) dont_walk_d = 1'b1;
      else if (tick)          dont_walk_d = ~dont_walk_q;
      else                    dont_walk_d = dont_walk_q;
    end else begin
      dont_walk_d = (state_d != S_WALK);
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      walk_req_q   <= 1'b0;
      walk_done_q  <= 1'b0;
      wr_reset_q   <= 1'b0;
      walk_light_q <= 1'b0;
      dont_walk_q  <= 1'b1;
      walk_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      walk_req_q   <= walk_req_d;
      walk_done_q  <= walk_done_d;
      wr_reset_q   <= wr_reset_d;
      walk_light_q <= walk_light_d;
      dont_walk_q  <= dont_walk_d;
      walk_busy_q  <= walk_busy_d;
    end
  end

  assign walk_req           = walk_req_q;
  assign walk_done          = walk_done_q;
  assign walkRegister_reset = wr_reset_q;
  assign walk_light         = walk_light_q;
  assign dont_walk_light    = dont_walk_q;
  assign walk_busy          = walk_busy_q;

endmodule

// File: tb/tb_walk_service_controller.sv
module tb_walk_service_controller;

  localparam int WALK_T  = 3;
  localparam int FLASH_T = 2;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WALK  = 2;
  localparam int P_FLASH = 3;
  localparam int P_DONE  = 4;

  logic clk = 1'b0;
  logic sys_reset = 1'b1;
  logic tick = 1'b0;
  logic walkRegister_status = 1'b0;
  logic walk_ack = 1'b0;
  logic walk_req, walk_done, walkRegister_reset, walk_light, dont_walk_light, walk_busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // Observed pulse/tick tallies per walk, checked against hand-computed values.
  int wl_ticks = 0;
  int fl_ticks = 0;
  int wrr_pulses = 0;
  int done_pulses = 0;
  bit seen_walk = 1'b0;

  walk_service_controller #(
    .WALK_TIME (WALK_T),
    .FLASH_TIME(FLASH_T),
    .CNT_W     (8)
  ) dut (
    .clk                (clk),
    .sys_reset          (sys_reset),
    .tick               (tick),
    .walkRegister_status(walkRegister_status),
    .walk_ack           (walk_ack),
    .walk_req           (walk_req),
    .walk_done          (walk_done),
    .walkRegister_reset (walkRegister_reset),
    .walk_light         (walk_light),
    .dont_walk_light    (dont_walk_light),
    .walk_busy          (walk_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus number of ticks already spent in the phase.
  int m_phase = P_IDLE;
  int m_ticks = 0;
  bit m_first = 1'b0;

  always @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      m_phase <= P_IDLE;
      m_ticks <= 0;
      m_first <= 1'b0;
    end else begin
      m_first <= 1'b0;
      case (m_phase)
        P_IDLE: if (walkRegister_status && !walk_ack) m_phase <= P_REQ;
        P_REQ: if (walk_ack) begin
          m_phase <= P_WALK;
          m_ticks <= 0;
          m_first <= 1'b1;
        end
        P_WALK: if (tick) begin
          if (m_ticks + 1 == WALK_T) begin m_phase <= P_FLASH; m_ticks <= 0; end
          else m_ticks <= m_ticks + 1;
        end
        P_FLASH: if (tick) begin
          if (m_ticks + 1 == FLASH_T) begin m_phase <= P_DONE; m_ticks <= 0; end
          else m_ticks <= m_ticks + 1;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Compare every cycle on the falling edge, and tally per-walk events.
  always @(negedge clk) begin
    logic exp_dwl;
    if (m_phase == P_WALK)       exp_dwl = 1'b0;
    else if (m_phase == P_FLASH) exp_dwl = ((m_ticks % 2) == 0);
    else                         exp_dwl = 1'b1;
    chk("walk_req", 32'(walk_req), 32'((m_phase == P_REQ) || (m_phase == P_WALK) || (m_phase == P_FLASH)));
    chk("walk_done", 32'(walk_done), 32'(m_phase == P_DONE));
    chk("walkRegister_reset", 32'(walkRegister_reset), 32'((m_phase == P_WALK) && m_first));
    chk("walk_light", 32'(walk_light), 32'(m_phase == P_WALK));
    chk("dont_walk_light", 32'(dont_walk_light), 32'(exp_dwl));
    chk("walk_busy", 32'(walk_busy), 32'(m_phase != P_IDLE));

    if (walk_light) seen_walk = 1'b1;
    if (walk_light && tick) wl_ticks++;
    if (seen_walk && walk_req && !walk_light && tick) fl_ticks++;
    if (walkRegister_reset) wrr_pulses++;
    if (walk_done) begin done_pulses++; seen_walk = 1'b0; end
  end

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    tick = ((cyc_cnt % 4) == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0: return walk_req;
      1: return walk_light;
      2: return !walk_light;
      3: return walk_done;
      default: return tick;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string name);
    int n;
    n = 0;
    while (!sel_sig(sel) && n < budget) begin
      step();
      n++;
    end
    if (!sel_sig(sel)) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic clr_counts();
    wl_ticks = 0;
    fl_ticks = 0;
    wrr_pulses = 0;
    done_pulses = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " walk ticks"}, 32'(wl_ticks), 32'd3);
    chk({tag, " flash ticks"}, 32'(fl_ticks), 32'd2);
    chk({tag, " clear pulses"}, 32'(wrr_pulses), 32'd1);
    chk({tag, " done pulses"}, 32'(done_pulses), 32'd1);
  endtask

  initial begin
    #1 sys_reset = 1'b0;
    steps(3);
    chk("reset dont_walk", 32'(dont_walk_light), 32'd1);
    chk("reset walk_req", 32'(walk_req), 32'd0);
    sys_reset = 1'b1;
    steps(2);

    // Basic cycle with the grant held through DONE.
    clr_counts();
    walkRegister_status = 1'b1;
    step();
    chk("req latency", 32'(walk_req), 32'd1);
    walk_ack = 1'b1;
    step();
    chk("walk entry clear", 32'(walkRegister_reset), 32'd1);
    chk("walk entry lamp", 32'(walk_light), 32'd1);
    walkRegister_status = 1'b0;
    step();
    chk("clear is one cycle", 32'(walkRegister_reset), 32'd0);
    wait_until(2, 40, "flash entry A");
    walkRegister_status = 1'b1;   // button pressed during FLASH
    wait_until(3, 40, "done A");
    step();
    chk("req low after done", 32'(walk_req), 32'd0);
    chk_counts("A");

    // Stale grant: pending walk but ack still high keeps IDLE.
    steps(6);
    chk("stale ack idle", 32'(walk_busy), 32'd0);
    walk_ack = 1'b0;
    step();
    chk("re-request after ack drop", 32'(walk_req), 32'd1);

    // Ticks in REQ are ignored; grant withdrawn after the first WALK tick.
    clr_counts();
    steps(10);
    chk("still in REQ", 32'(walk_light), 32'd0);
    walk_ack = 1'b1;
    step();
    chk("walk entry clear B", 32'(walkRegister_reset), 32'd1);
    walkRegister_status = 1'b0;
    step();
    wait_until(4, 10, "first walk tick B");
    step();
    walk_ack = 1'b0;
    wait_until(3, 40, "done B");
    steps(3);
    chk("idle after B", 32'(walk_busy), 32'd0);
    chk_counts("B");

    // Asynchronous reset in the middle of WALK.
    walkRegister_status = 1'b1;
    step();
    walk_ack = 1'b1;
    step();
    walkRegister_status = 1'b0;
    step();
    chk("walk before reset", 32'(walk_light), 32'd1);
    #2 sys_reset = 1'b0;
    #1;
    chk("async rst walk_light", 32'(walk_light), 32'd0);
    chk("async rst dont_walk", 32'(dont_walk_light), 32'd1);
    chk("async rst walk_req", 32'(walk_req), 32'd0);
    chk("async rst busy", 32'(walk_busy), 32'd0);
    walk_ack = 1'b0;
    steps(2);
    sys_reset = 1'b1;
    steps(3);
    chk("idle after reset", 32'(walk_busy), 32'd0);
    chk("solid dont_walk after reset", 32'(dont_walk_light), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/walk_service_controller.md
# walk_service_controller

Services pedestrian walk requests latched by the walk register. Monitors `walkRegister_status`, negotiates a walk slot with the main vehicle-phase controller via a req/ack handshake, and times the WALK and flashing DON'T-WALK intervals on a one-cycle `tick` enable. Clears the walk register at the start of each serviced walk. Sits between the walk register and the main traffic sequencer.

## Interface
- `WALK_TIME`, default 8: WALK interval length in ticks; must be ≥1.
- `FLASH_TIME`, default 4: flashing DON'T-WALK interval length in ticks; must be ≥1.
- `CNT_W`, default 8: tick counter width; must satisfy 2^CNT_W > max(WALK_TIME, FLASH_TIME).
- `clk` input 1: system clock; all state changes on its rising edge.
- `sys_reset` input 1: asynchronous, active-low reset (0 = reset).
- `tick` input 1: one-cycle timebase enable, for example 1 Hz.
- `walkRegister_status` input 1: pending-walk flag from the walk register.
- `walk_ack` input 1: main controller grant; all vehicle heads are red.
- `walk_req` output 1: request for a walk slot.
- `walk_done` output 1: one-cycle pulse; walk slot released.
- `walkRegister_reset` output 1: one-cycle clear pulse to the walk register.
- `walk_light` output 1: WALK lamp.
- `dont_walk_light` output 1: DON'T-WALK lamp.
- `walk_busy` output 1: high in any state except IDLE.

## Operation
- **States:** IDLE, REQ, WALK, FLASH, DONE.
- **Reset values:** state IDLE, counter 0, `walk_req`=0, `walk_done`=0, `walkRegister_reset`=0, `walk_light`=0, `dont_walk_light`=1, `walk_busy`=0.
- **IDLE → REQ:** when `walkRegister_status`=1 and `walk_ack`=0. If `walk_ack` is still 1 from a prior slot, stay in IDLE.
- **REQ:**
  - `walk_req`=1.
  - On `walk_ack`=1, go to WALK and load counter with WALK_TIME-1.
  - `tick` is ignored in REQ.
- **WALK:**
  - `walk_req`=1, `walk_light`=1, `dont_walk_light`=0.
  - `walkRegister_reset`=1 on the first WALK cycle only.
  - On `tick`: if counter=0, go to FLASH, load FLASH_TIME-1, and set `dont_walk_light`=1. Otherwise decrement.
- **FLASH:**
  - `walk_req`=1, `walk_light`=0.
  - `dont_walk_light` toggles on every `tick`.
  - On `tick` with counter=0, go to DONE. Otherwise decrement on `tick`.
- **DONE:**
  - Lasts one cycle: `walk_done`=1, `walk_req`=0, `dont_walk_light`=1, `walk_light`=0.
  - Always returns to IDLE.
- **`walk_ack` sampling:** only in REQ and IDLE. A deassertion during WALK/FLASH is ignored; the timing completes.
- **Requests during a walk:** a button press during WALK/FLASH re-latches in the walk register. After DONE, IDLE re-requests once `walk_ack` has dropped.
- **Counter arithmetic:** unsigned CNT_W bits. It never underflows, because it is reloaded before wrap.
- **Reset mid-operation:** any state returns immediately to reset values; lamps go to solid DON'T-WALK.

## Timing
- **`walk_req` assertion:** the cycle after IDLE sees status=1 and ack=0 (registered, 1-cycle latency).
- **WALK entry:** the cycle after `walk_ack` is sampled high in REQ. `walkRegister_reset` is high that same cycle, so the register clears on the following edge.
- **WALK duration:** ends on the edge after the WALK_TIME-th tick counted from the WALK entry cycle inclusive. FLASH is measured the same way with FLASH_TIME.
- **Tick on the first WALK cycle:** counts as tick 1.
- **Simultaneous status=1 and ack=1 in IDLE:** stay in IDLE.
- **Simultaneous tick and entry edge:** the tick is not counted for the state being left.

## Test plan
- **Reset:** assert `sys_reset`=0 mid-WALK → all outputs at reset values asynchronously (`dont_walk_light`=1, others 0). Release → IDLE.
- **Basic cycle** (WALK_TIME=3, FLASH_TIME=2, tick every 4 cycles):
  - status=1, ack=0 → `walk_req`=1 next cycle.
  - ack=1 → WALK with a 1-cycle `walkRegister_reset` pulse.
  - `walk_light` is high for exactly 3 ticks, then `dont_walk_light` toggles on 2 ticks.
  - `walk_done` pulses 1 cycle, then `walk_req`=0.
- **Stale ack:** keep ack=1 after DONE with status=1 → stays IDLE. Drop ack → `walk_req` rises next cycle.
- **Mid-walk request:** status re-sets during FLASH → after DONE, a new `walk_req` once ack=0. Exactly one `walkRegister_reset` pulse per WALK.
- **Ack withdrawn in WALK:** ack→0 at tick 1 → WALK still lasts 3 ticks; FLASH and DONE still occur.
- **No tick in REQ:** ticks during REQ with ack=0 → counter untouched. Once ack=1, WALK still lasts WALK_TIME ticks.
